// File: rtl/hamming1511_serial_encoder.sv
// Hamming(15,11) encoder with a one-entry pending buffer and a gapless framed serializer.
// Optional macro HAMMING_ERR_INJECT_EN adds inj_en/inj_pos single-bit fault injection at acceptance.
module hamming1511_serial_encoder #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] in_data,
    input  logic        ser_en,
    output logic        ser_out,
    output logic        ser_valid,
    output logic        ser_frame,
    output logic [14:0] cw_out,
    output logic        cw_valid,
    output logic [15:0] frame_cnt
`ifdef HAMMING_ERR_INJECT_EN
    ,
    input  logic        inj_en,
    input  logic [3:0]  inj_pos
`endif
);

    localparam int unsigned DATA_W   = 11;
    localparam int unsigned CW_W     = 15;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned FCNT_W   = 16;
    localparam int unsigned LAST_BIT = CW_W - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CW_W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CW_W-1:0]     pend_q, pend_d;
    logic                pend_valid_q, pend_valid_d;
    logic                ser_out_q, ser_out_d;
    logic                ser_valid_q, ser_valid_d;
    logic                ser_frame_q, ser_frame_d;
    logic [CW_W-1:0]     cw_q, cw_d;
    logic                cw_valid_q, cw_valid_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                in_ready_q, in_ready_d;

    logic [CW_W-1:0]     cw_enc;
    logic [DATA_W-1:0]   d;
    logic                p1, p2, p3, p4;
    logic                accept;
    logic                load;
    logic [CW_W-1:0]     load_word;

    assign accept = in_valid && in_ready_q;

    // Combinational encode of the incoming word into the decoder's bit layout
    always_comb begin
        d  = in_data;
        p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
        p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
        p3 = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        p4 = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        cw_enc = {d[10:4], p4, d[3:1], p3, d[0], p2, p1};
`ifdef HAMMING_ERR_INJECT_EN
        if (inj_en && (inj_pos != 4'hF)) begin
            cw_enc = cw_enc ^ (CW_W'(1) << inj_pos);
        end
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        ser_out_d    = ser_out_q;
        ser_valid_d  = ser_valid_q;
        ser_frame_d  = ser_frame_q;
        cw_d         = cw_q;
        cw_valid_d   = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        load         = 1'b0;
        load_word    = cw_enc;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (ser_en && (cnt_q == CNT_W'(LAST_BIT))) begin
                    frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                    if (pend_valid_q) begin
                        load         = 1'b1;
                        load_word    = pend_q;
                        pend_valid_d = 1'b0;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        ser_out_d   = 1'b0;
                        ser_valid_d = 1'b0;
                        ser_frame_d = 1'b0;
                    end
                end else begin
                    if (accept) begin
                        pend_d       = cw_enc;
                        pend_valid_d = 1'b1;
                    end
                    if (ser_en) begin
                        ser_out_d   = MSB_FIRST ? shift_q[CW_W-1] : shift_q[0];
                        shift_d     = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                        cnt_d       = cnt_q + CNT_W'(1);
                        ser_frame_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A load presents bit 0 immediately and keeps the rest in the shifter
        if (load) begin
            state_d     = SHIFT;
            cw_d        = load_word;
            ser_out_d   = MSB_FIRST ? load_word[CW_W-1] : load_word[0];
            shift_d     = MSB_FIRST ? (load_word << 1) : (load_word >> 1);
            cnt_d       = '0;
            ser_valid_d = 1'b1;
            ser_frame_d = 1'b1;
            cw_valid_d  = 1'b1;
        end

        in_ready_d = !pend_valid_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            ser_frame_q  <= 1'b0;
            cw_q         <= '0;
            cw_valid_q   <= 1'b0;
            frame_cnt_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            ser_frame_q  <= ser_frame_d;
            cw_q         <= cw_d;
            cw_valid_q   <= cw_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_frame = ser_frame_q;
    assign cw_out    = cw_q;
    assign cw_valid  = cw_valid_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_hamming1511_serial_encoder.sv
// Self-checking bench for hamming1511_serial_encoder: LSB-first and MSB-first instances
// compared each cycle against a queue-of-bits reference built from positional Hamming rules.
module tb_hamming1511_serial_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [10:0] in_data;
    logic        ser_en;

    logic        in_ready, ser_out, ser_valid, ser_frame, cw_valid;
    logic [14:0] cw_out;
    logic [15:0] frame_cnt;

    logic        m_in_ready, m_ser_out, m_ser_valid, m_ser_frame, m_cw_valid;
    logic [14:0] m_cw_out;
    logic [15:0] m_frame_cnt;

`ifdef HAMMING_ERR_INJECT_EN
    logic        inj_en;
    logic [3:0]  inj_pos;
`endif

    always #5 clk = ~clk;

    hamming1511_serial_encoder #(.MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .ser_en(ser_en), .ser_out(ser_out), .ser_valid(ser_valid),
        .ser_frame(ser_frame), .cw_out(cw_out), .cw_valid(cw_valid), .frame_cnt(frame_cnt)
`ifdef HAMMING_ERR_INJECT_EN
        , .inj_en(inj_en), .inj_pos(inj_pos)
`endif
    );

    hamming1511_serial_encoder #(.MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_data(in_data), .ser_en(ser_en), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
        .ser_frame(m_ser_frame), .cw_out(m_cw_out), .cw_valid(m_cw_valid), .frame_cnt(m_frame_cnt)
`ifdef HAMMING_ERR_INJECT_EN
        , .inj_en(inj_en), .inj_pos(inj_pos)
`endif
    );

    typedef struct packed {
        logic [14:0] cw;
        logic [3:0]  idx;
    } ent_t;

    ent_t        bitq[$];
    logic [15:0] exp_fc;
    logic [14:0] exp_cw;
    logic        exp_cwv;
    int          tests = 0;
    int          fails = 0;

    // Positional Hamming: data fills non-power-of-two positions, parity k covers positions with bit k set
    function automatic logic [14:0] ref_enc(input logic [10:0] dw);
        logic [14:0] c;
        int k;
        logic par;
        c = '0;
        k = 0;
        for (int pos = 1; pos <= 15; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = dw[k];
                k++;
            end
        end
        for (int p = 0; p < 4; p++) begin
            par = 1'b0;
            for (int pos = 1; pos <= 15; pos++) begin
                if ((((pos >> p) & 1) == 1) && (pos != (1 << p))) par = par ^ c[pos-1];
            end
            c[(1 << p) - 1] = par;
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int   n;
        ent_t h;
        int   j;
        n = bitq.size();
        h = '0;
        if (n != 0) h = bitq[0];
        chk("in_ready", 32'(in_ready), 32'(n <= 15));
        chk("ser_valid", 32'(ser_valid), 32'(n != 0));
        chk("ser_frame", 32'(ser_frame), 32'((n != 0) && (h.idx == 4'd0)));
        chk("cw_valid", 32'(cw_valid), 32'(exp_cwv));
        chk("cw_out", 32'(cw_out), 32'(exp_cw));
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        chk("m_ser_valid", 32'(m_ser_valid), 32'(n != 0));
        chk("m_cw_out", 32'(m_cw_out), 32'(exp_cw));
        if (n != 0) begin
            j = 14 - int'(h.idx);
            chk("ser_out_lsb", 32'(ser_out), 32'(h.cw[h.idx]));
            chk("ser_out_msb", 32'(m_ser_out), 32'(h.cw[j]));
        end
    endtask

    task automatic cycle(output bit acc);
        bit          pop, was_empty, changed;
        logic [14:0] cw;
        ent_t        e;
        acc       = in_valid && (bitq.size() <= 15);
        pop       = ser_en && (bitq.size() != 0);
        was_empty = (bitq.size() == 0);
        cw        = ref_enc(in_data);
`ifdef HAMMING_ERR_INJECT_EN
        if (inj_en && (inj_pos != 4'd15)) cw[inj_pos] = ~cw[inj_pos];
`endif
        @(posedge clk);
        #1;
        if (pop) begin
            e = bitq.pop_front();
            if (e.idx == 4'd14) exp_fc = exp_fc + 16'd1;
        end
        if (acc) begin
            for (int i = 0; i < 15; i++) begin
                e.cw  = cw;
                e.idx = 4'(i);
                bitq.push_back(e);
            end
        end
        changed = pop || (was_empty && acc);
        exp_cwv = (bitq.size() != 0) && changed && (bitq[0].idx == 4'd0);
        if (bitq.size() != 0) exp_cw = bitq[0].cw;
        check_outputs();
    endtask

    task automatic send(input logic [10:0] w);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 40 && !acc; i++) cycle(acc);
        in_valid = 1'b0;
        chk("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        bit acc;
        ser_en = 1'b1;
        for (int i = 0; i < 100 && bitq.size() != 0; i++) cycle(acc);
        chk("drain_idle", 32'(ser_valid), 32'd0);
    endtask

    // Asynchronous reset between edges; model returns to its power-on state
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        bitq.delete();
        exp_fc  = '0;
        exp_cw  = '0;
        exp_cwv = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_ser_out", 32'(ser_out), 32'd0);
        chk("rst_ser_valid", 32'(ser_valid), 32'd0);
        chk("rst_ser_frame", 32'(ser_frame), 32'd0);
        chk("rst_cw_out", 32'(cw_out), 32'd0);
        chk("rst_cw_valid", 32'(cw_valid), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_m_ser_valid", 32'(m_ser_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit          acc;
        int          nacc, nvalid, first_v, last_v;
        int          offs[$];
        bit          saw_busy;
        logic [10:0] words[3];
        logic        held;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        ser_en   = 1'b1;
`ifdef HAMMING_ERR_INJECT_EN
        inj_en   = 1'b0;
        inj_pos  = 4'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // All-zero then all-ones words back to back
        send(11'h000);
        chk("cw_zero", 32'(cw_out), 32'h0000);
        send(11'h7FF);
        repeat (14) cycle(acc);
        chk("cw_ones", 32'(cw_out), 32'h7FFF);
        chk("cw_ones_valid", 32'(cw_valid), 32'd1);
        drain();
        chk("frame_cnt_two", 32'(frame_cnt), 32'd2);

        // Single data bit d0 and d10
        send(11'h001);
        chk("cw_001", 32'(cw_out), 32'h0007);
        chk("first_lsb_001", 32'(ser_out), 32'd1);
        chk("first_msb_001", 32'(m_ser_out), 32'd0);
        chk("frame_first_001", 32'(ser_frame), 32'd1);
        drain();
        send(11'h400);
        chk("cw_400", 32'(cw_out), 32'h408B);
        chk("first_msb_400", 32'(m_ser_out), 32'd1);
        drain();

        // Three words with in_valid held high
        for (int i = 0; i < 3; i++) words[i] = 11'($urandom);
        nacc = 0; nvalid = 0; first_v = -1; last_v = -1; saw_busy = 1'b0;
        offs.delete();
        for (int c = 0; c < 60; c++) begin
            in_valid = (nacc < 3);
            in_data  = words[(nacc < 3) ? nacc : 2];
            cycle(acc);
            if (acc) nacc++;
            if (ser_valid) begin
                if (ser_frame) offs.push_back(nvalid);
                if (first_v < 0) first_v = c;
                last_v = c;
                nvalid++;
            end
            if (!in_ready) saw_busy = 1'b1;
        end
        in_valid = 1'b0;
        chk("three_valid_cnt", 32'(nvalid), 32'd45);
        chk("three_valid_span", 32'(last_v - first_v + 1), 32'd45);
        chk("three_frames", 32'(offs.size()), 32'd3);
        if (offs.size() == 3) begin
            chk("frame_off0", 32'(offs[0]), 32'd0);
            chk("frame_off1", 32'(offs[1]), 32'd15);
            chk("frame_off2", 32'(offs[2]), 32'd30);
        end
        chk("ready_low_seen", 32'(saw_busy), 32'd1);

        // Stall mid-frame at bit 6
        send(11'($urandom));
        repeat (6) cycle(acc);
        held   = ser_out;
        ser_en = 1'b0;
        repeat (5) cycle(acc);
        chk("stall_hold", 32'(ser_out), 32'(held));
        chk("stall_valid", 32'(ser_valid), 32'd1);
        drain();

        // Reset during a frame discards it
        do_reset();
        send(11'($urandom));
        repeat (5) cycle(acc);
        do_reset();
        chk("midreset_fc", 32'(frame_cnt), 32'd0);
        send(11'($urandom));
        drain();
        chk("after_reset_fc", 32'(frame_cnt), 32'd1);

`ifdef HAMMING_ERR_INJECT_EN
        inj_en = 1'b1; inj_pos = 4'd2;
        send(11'h001);
        chk("inj_pos2", 32'(cw_out), 32'h0003);
        inj_en = 1'b0;
        drain();
        inj_en = 1'b1; inj_pos = 4'd15;
        send(11'h001);
        chk("inj_pos15", 32'(cw_out), 32'h0007);
        inj_en = 1'b0;
        drain();
        inj_en = 1'b0; inj_pos = 4'd2;
        send(11'h001);
        chk("inj_off", 32'(cw_out), 32'h0007);
        drain();
`endif

        // Random traffic with random downstream stalls
        for (int c = 0; c < 400; c++) begin
            in_valid = 1'($urandom);
            in_data  = 11'($urandom);
            ser_en   = (($urandom % 4) != 0);
`ifdef HAMMING_ERR_INJECT_EN
            inj_en   = 1'($urandom);
            inj_pos  = 4'($urandom);
`endif
            cycle(acc);
        end
        in_valid = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
        inj_en = 1'b0;
`endif
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
